mem_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port data memory (`datamem`, synchronous read) between N_REQ independent requesters, e.g. several GPU clusters or cluster plus host loader.
- Issues at most one access per cycle and tags read returns back to the issuing requester.
- Sits between the requesters' per-cluster memory controllers and `datamem`.

---
 rtl/mem_rr_arbiter_pkg.sv | 16 +
 rtl/mem_rr_arbiter_rr_pick.sv | 32 +++
 rtl/mem_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_rr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared constants and FSM encoding for the datamem round-robin arbiter.
// Requester count defaults track the cluster count (N_CORES).
package mem_rr_arbiter_pkg;

  localparam int N_CORES     = 4;
  localparam int N_CORES_LOG = 2;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Rotating priority pick: first set bit of req scanning ptr, ptr+1, ... mod N.
// Ports: req, ptr in; one-hot gnt, winner idx and any-request flag out.
module mem_rr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int NL = 2
) (
  input  logic [N-1:0]  req,
  input  logic [NL-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [NL-1:0] idx,
  output logic          any
);

  logic [NL-1:0] cand;

  // N is a power of two, so the NL-bit add wraps modulo N.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + NL'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing single-port datamem among N_REQ requesters.
// Ports: req/we/addr/wdata/lock in, gnt/rvalid/rdata out, datamem side
// addr_mem/data_to_mem/wren/data_from_mem. Option: MEM_ARB_LOCK_EN.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_CORES,
  parameter int N_REQ_LOG = N_CORES_LOG,
  parameter int AW        = ADDR_W,
  parameter int DW        = DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       rdata,
  output logic [N_REQ-1:0]    rvalid,
  output logic [AW-1:0]       addr_mem,
  output logic [DW-1:0]       data_to_mem,
  output logic                wren,
  input  logic [DW-1:0]       data_from_mem,
  input  logic [N_REQ-1:0]    lock
);

  localparam logic [N_REQ_LOG-1:0] ONE = N_REQ_LOG'(1);

  arb_state_t           state;
  logic [N_REQ_LOG-1:0] ptr;
  logic [N_REQ_LOG-1:0] base;
  logic [N_REQ_LOG-1:0] win;
  logic [N_REQ-1:0]     elig;
  logic [N_REQ-1:0]     pick;
  logic                 any;
  logic                 issue;
  logic                 rd_issue;
  logic                 rd_pend;
  logic [DW-1:0]        rdata_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wd_q;

`ifdef MEM_ARB_LOCK_EN
  logic [N_REQ_LOG-1:0] owner;
  logic                 locked;
  logic                 hold;

  assign locked = (state == ST_LOCKED);
  assign hold   = locked && lock[owner];
  // While held only the owner may issue; on the release
  // cycle arbitration resumes just past the owner.
  assign elig = hold ? (req & (N_REQ'(1) << owner)) : req;
  assign base = locked ? owner + ONE : ptr;
`else
  logic unused_lock;

  assign unused_lock = ^{lock, state};
  assign elig        = req;
  assign base        = ptr;
`endif

  mem_rr_arbiter_rr_pick #(
    .N  (N_REQ),
    .NL (N_REQ_LOG)
  ) u_pick (
    .req (elig),
    .ptr (base),
    .gnt (pick),
    .idx (win),
    .any (any)
  );

  assign issue    = any && !reset;
  assign rd_issue = issue && !we[win];

  assign gnt         = issue ? pick : '0;
  assign wren        = issue && we[win];
  assign addr_mem    = issue ? addr[win*AW +: AW] : addr_q;
  assign data_to_mem = issue ? wdata[win*DW +: DW] : wd_q;
  // datamem returns the word one cycle after the address.
  assign rdata       = rd_pend ? data_from_mem : rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      rvalid  <= '0;
      rd_pend <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
      owner   <= '0;
`endif
    end else begin
      rd_pend <= rd_issue;
      rvalid  <= rd_issue ? pick : '0;
      if (rd_pend) rdata_q <= data_from_mem;
      if (issue) begin
        addr_q <= addr[win*AW +: AW];
        wd_q   <= wdata[win*DW +: DW];
      end
`ifdef MEM_ARB_LOCK_EN
      if (hold) begin
        state <= ST_LOCKED;
      end else if (issue && lock[win]) begin
        state <= ST_LOCKED;
        owner <= win;
      end else if (issue) begin
        state <= ST_ACTIVE;
        ptr   <= win + ONE;
      end else begin
        state <= ST_IDLE;
        if (locked) ptr <= owner + ONE;
      end
`else
      state <= issue ? ST_ACTIVE : ST_IDLE;
      if (issue) ptr <= win + ONE;
`endif
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, data_to_mem;
  logic [DW-1:0]   data_from_mem = '0;
  logic [AW-1:0]   addr_mem;
  logic            wren;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .addr_mem      (addr_mem),
    .data_to_mem   (data_to_mem),
    .wren          (wren),
    .data_from_mem (data_from_mem),
    .lock          (lock)
  );

  always @(posedge clk) begin
    if (wren) mem[addr_mem] <= data_to_mem;
    data_from_mem <= mem[addr_mem];
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] we;
    logic [3:0] gnt;
    logic       wren;
  } vec_t;

  vec_t tab [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int g [6];
    logic [DW-1:0] vals [4];
    int mptr, w, idx, pend_w;
    bit pend_rd;
    bit rq_p [N];
    logic [DW-1:0] pend_val, last_rd, exp_d;
    logic [AW-1:0] last_a, a, exp_a;
    logic [N-1:0]  exp_g, exp_v;

    reset = 1'b1;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    mem[10] <= 16'd9;
    mem[11] <= 16'd20;
    mem[12] <= 16'd55;
    mem[13] <= 16'd24;
    for (int i = 0; i < 64; i++) begin
      mem[64+i]  <= DW'((64 + i) * 3);
      ref_mem[i]  = DW'((64 + i) * 3);
    end

    tab[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tab[1] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    tab[2] = '{4'b0101, 4'b0000, 4'b0001, 1'b0};
    tab[3] = '{4'b0101, 4'b0000, 4'b0100, 1'b0};
    tab[4] = '{4'b1111, 4'b0000, 4'b1000, 1'b0};
    tab[5] = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    tab[6] = '{4'b0001, 4'b0000, 4'b0001, 1'b0};
    tab[7] = '{4'b1010, 4'b0010, 4'b0010, 1'b1};
    tab[8] = '{4'b0011, 4'b0000, 4'b0001, 1'b0};
    tab[9] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};

    // reset state with every requester asking to write
    repeat (2) @(posedge clk);
    #1;
    req = '1; we = '1;
    for (int i = 0; i < N; i++) set_rq(i, 1'b1, AW'(100 + i), DW'(i + 1));
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_wren", 32'(wren), 32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_addr_mem", 32'(addr_mem), 32'(0));
    chk("rst_data_to_mem", 32'(data_to_mem), 32'(0));
    tick();
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++)
        set_rq(i, tab[v].we[i], AW'(200 + i), DW'(300 + i));
      req = tab[v].req;
      @(negedge clk);
      chk($sformatf("tab%0d_gnt", v), 32'(gnt), 32'(tab[v].gnt));
      chk($sformatf("tab%0d_wren", v), 32'(wren), 32'(tab[v].wren));
      tick();
    end

    // single reader, ptr 1 -> 3
    set_rq(2, 1'b0, 16'd12, 16'd0);
    req = 4'b0100;
    @(negedge clk);
    chk("sr_gnt", 32'(gnt), 32'(4'b0100));
    chk("sr_addr", 32'(addr_mem), 32'd12);
    chk("sr_wren", 32'(wren), 32'(0));
    tick();
    req = '0;
    @(negedge clk);
    chk("sr_rvalid", 32'(rvalid), 32'(4'b0100));
    chk("sr_rdata", 32'(rdata), 32'd55);
    tick();
    @(negedge clk);
    chk("sr_rvalid_pulse", 32'(rvalid), 32'(0));
    chk("sr_rdata_hold", 32'(rdata), 32'd55);
    tick();

    // all four read continuously, starting at ptr 3
    g = '{3, 0, 1, 2, 3, 0};
    vals = '{16'd9, 16'd20, 16'd55, 16'd24};
    for (int i = 0; i < N; i++) set_rq(i, 1'b0, AW'(10 + i), '0);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1) << g[k]);
      if (k > 0) begin
        chk($sformatf("rr%0d_rvalid", k), 32'(rvalid), 32'(1) << g[k-1]);
        chk($sformatf("rr%0d_rdata", k), 32'(rdata), 32'(vals[g[k-1]]));
      end
      tick();
    end
    req = '0;
    @(negedge clk);
    chk("rr_last_rvalid", 32'(rvalid), 32'(1));
    chk("rr_last_rdata", 32'(rdata), 32'd9);
    tick();

    // write then read same address, ptr 1
    set_rq(1, 1'b1, 16'd40, 16'd77);
    req = 4'b0010;
    @(negedge clk);
    chk("wr_gnt", 32'(gnt), 32'(4'b0010));
    chk("wr_wren", 32'(wren), 32'(1));
    chk("wr_addr", 32'(addr_mem), 32'd40);
    chk("wr_data", 32'(data_to_mem), 32'd77);
    tick();
    set_rq(3, 1'b0, 16'd40, 16'd0);
    req = 4'b1000;
    @(negedge clk);
    chk("wr_no_rvalid", 32'(rvalid), 32'(0));
    chk("rd40_gnt", 32'(gnt), 32'(4'b1000));
    chk("rd40_wren", 32'(wren), 32'(0));
    tick();
    req = '0;
    @(negedge clk);
    chk("rd40_rvalid", 32'(rvalid), 32'(4'b1000));
    chk("rd40_rdata", 32'(rdata), 32'd77);
    chk("idle_addr_hold", 32'(addr_mem), 32'd40);
    chk("idle_wren", 32'(wren), 32'(0));
    tick();

    // wrap and skip: reach ptr 3, then req 0101
    set_rq(2, 1'b0, 16'd11, '0);
    req = 4'b0100;
    @(negedge clk);
    chk("ws_pre_gnt", 32'(gnt), 32'(4'b0100));
    tick();
    set_rq(0, 1'b0, 16'd10, '0);
    req = 4'b0101;
    @(negedge clk);
    chk("ws_wrap_gnt", 32'(gnt), 32'(4'b0001));
    tick();
    @(negedge clk);
    chk("ws_skip_gnt", 32'(gnt), 32'(4'b0100));
    tick();
    req = '0;
    tick();

    // reset in the return cycle of a read
    set_rq(0, 1'b0, 16'd12, '0);
    req = 4'b0001;
    @(negedge clk);
    chk("rm_gnt", 32'(gnt), 32'(4'b0001));
    tick();
    reset = 1'b1;
    req = '1; we = '1;
    #1;
    chk("rm_rvalid_async", 32'(rvalid), 32'(0));
    @(negedge clk);
    chk("rm_rvalid", 32'(rvalid), 32'(0));
    chk("rm_wren", 32'(wren), 32'(0));
    chk("rm_gnt_rst", 32'(gnt), 32'(0));
    tick();
    reset = 1'b0;
    req = '0; we = '0;
    @(negedge clk);
    chk("rm_rvalid_after", 32'(rvalid), 32'(0));
    tick();
    req = 4'b1111;
    @(negedge clk);
    chk("rm_ptr0_gnt", 32'(gnt), 32'(4'b0001));
    tick();
    req = '0;
    tick();
    tick();

`ifdef MEM_ARB_LOCK_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_rq(i, 1'b0, AW'(10 + i), '0);
    req = 4'b0001;
    @(negedge clk);
    chk("lk_pre_gnt", 32'(gnt), 32'(4'b0001));
    tick();
    req = 4'b0111;
    lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lk%0d_gnt", k), 32'(gnt), 32'(4'b0010));
      tick();
    end
    req = 4'b0101;
    lock = '0;
    @(negedge clk);
    chk("lk_release_gnt", 32'(gnt), 32'(4'b0100));
    tick();
    req = '0;
    tick();
`endif

    // randomized run against the reference model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mptr = 0; pend_rd = 0; pend_w = 0;
    pend_val = '0; last_rd = '0; last_a = '0;
    for (int i = 0; i < N; i++) rq_p[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) req[i] = rq_p[i];
`ifdef MEM_ARB_LOCK_EN
      lock = '0;
`else
      lock = N'($urandom);
`endif
      @(negedge clk);
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
      exp_g = (w >= 0) ? N'(1) << w : '0;
      exp_v = pend_rd ? N'(1) << pend_w : '0;
      exp_a = (w >= 0) ? addr[w*AW +: AW] : last_a;
      chk("rnd_gnt", 32'(gnt), 32'(exp_g));
      chk("rnd_wren", 32'(wren), 32'(w >= 0 && we[w]));
      chk("rnd_addr_mem", 32'(addr_mem), 32'(exp_a));
      if (w >= 0) begin
        exp_d = wdata[w*DW +: DW];
        chk("rnd_data_to_mem", 32'(data_to_mem), 32'(exp_d));
      end
      chk("rnd_rvalid", 32'(rvalid), 32'(exp_v));
      chk("rnd_rdata", 32'(rdata), 32'(pend_rd ? pend_val : last_rd));
      if (pend_rd) last_rd = pend_val;
      pend_rd = 0;
      if (w >= 0) begin
        a = addr[w*AW +: AW];
        last_a = a;
        if (we[w]) begin
          ref_mem[a[5:0]] = wdata[w*DW +: DW];
        end else begin
          pend_rd  = 1;
          pend_w   = w;
          pend_val = ref_mem[a[5:0]];
        end
        mptr = (w + 1) % N;
        rq_p[w] = 0;
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (!rq_p[i] && $urandom_range(1, 0) == 1) begin
          rq_p[i] = 1;
          set_rq(i, 1'($urandom_range(1, 0)),
                 AW'(64 + $urandom_range(63, 0)), DW'($urandom));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
